gesture_classify: RTL
=====================

GESTURE_CLASSIFY -- requirements
Module: gesture_classify

Interface
REQ-001 SHALL have parameter MIN_W, default 16, meaning the minimum bounding-box width in pixels for a hand to be present.
REQ-002 SHALL have parameter MIN_H, default 16, meaning the minimum bounding-box height in pixels for a hand to be present.
REQ-003 SHALL have parameters TH1, TH2 and TH3, defaults 40, 25 and 15, meaning descending fingertip_data bin thresholds (TH1>TH2>TH3).
REQ-004 SHALL have parameter STABLE_N, default 3, meaning the number of consecutive identical raw classes required to commit a gesture.
REQ-005 SHALL have parameter TIMEOUT, default 2000000, meaning the number of cycles without a new frame result before the committed gesture is dropped.
REQ-006 SHALL have these ports:
clk  in  1  system clock; the only clock; all logic on its rising edge.
rst_n  in  1  synchronous, active-low reset.
en  in  1  result-valid level from the detector; high from end-of-window until next frame start.
x_min, x_max  in  12 each  bounding-box column limits.
y_min, y_max  in  12 each  bounding-box row limits.
fingertip_data  in  20  area/perimeter ratio from the detector.
raw_class  out  3  per-frame unfiltered class.
gesture  out  3  committed, filtered gesture code.
gesture_valid  out  1  single-cycle pulse when gesture changes.
no_frame  out  1  high while the timeout condition holds.
frame_cnt  out  16  frames classified, wrapping.

Function
REQ-007 SHALL register en each cycle and SHALL define strobe as en high with the registered en low (rising edge).
REQ-008 SHALL implement FSM states IDLE, CLASS, FILT, COMMIT; IDLE->CLASS on strobe, CLASS->FILT, FILT->COMMIT, COMMIT->IDLE, one cycle each.
REQ-009 SHALL ignore a strobe arriving outside IDLE; it is not queued.
REQ-010 SHALL, in CLASS, capture the inputs sampled on the strobe cycle, compute w=x_max-x_min and h=y_max-y_min only when max>min (else treat as 0), and register raw_class.
REQ-011 SHALL assign raw_class 0 if w<MIN_W or h<MIN_H; otherwise 1 if fingertip_data>=TH1, 2 if >=TH2, 3 if >=TH3, else 4.
REQ-012 SHALL, in FILT, compare raw_class against the held candidate: if equal, increment stable count saturating at STABLE_N; if different, load the candidate with raw_class and set count to 1.
REQ-013 SHALL, in COMMIT, set gesture to the candidate when count==STABLE_N and the candidate differs from gesture, asserting gesture_valid for exactly that cycle (strobe cycle +3).
REQ-014 SHALL increment frame_cnt by 1 in COMMIT, wrapping 0xFFFF->0.
REQ-015 SHALL count cycles since the last accepted strobe in a saturating counter; on reaching TIMEOUT-1, it SHALL set no_frame=1, force gesture to 0, clear the candidate and count, and pulse gesture_valid once if gesture was nonzero.
REQ-016 SHALL give an accepted strobe priority over a coincident timeout: clear the timeout counter and no_frame, with no forced drop that cycle.
REQ-017 SHALL hold no_frame low from the first accepted strobe onward until the next timeout.
REQ-018 SHALL never update gesture from a raw class of 0 before it is committed through the STABLE_N filter; 0 filters like any other class.

Reset
REQ-019 SHALL, while rst_n=0 on a clk edge, set FSM=IDLE, raw_class=0, gesture=0, gesture_valid=0, no_frame=0, frame_cnt=0, candidate=0, stable count=0, timeout counter=0 and registered en=0.
REQ-020 SHALL, on reset asserted mid-sequence (any non-IDLE state), abort without a gesture_valid pulse and resume in IDLE.
REQ-021 SHALL treat en already high on the first cycle after reset release as a strobe, because registered en is 0.

Verification
REQ-022 SHALL cover this case: three frames with box (150,300,50,250) and fingertip_data=50 -> raw_class=1 each frame, gesture 0->1 with gesture_valid at frame-3 strobe+3, frame_cnt=3.
REQ-023 SHALL cover this case: frames with raw classes 2,2,3,3,3 -> no commit after the 2s, gesture=3 committed after the third 3.
REQ-024 SHALL cover this case: a box of width 10 with fingertip_data=50 -> raw_class=0, and three such frames with gesture=1 beforehand -> gesture=0 with a valid pulse.
REQ-025 SHALL cover this case: TIMEOUT=100, gesture=2, no strobe for 100 cycles -> no_frame=1, gesture=0, exactly one valid pulse; a following strobe -> no_frame=0.
REQ-026 SHALL cover this case: a strobe on the same cycle the timeout counter hits TIMEOUT-1 -> no drop, counter cleared, classification proceeds.
REQ-027 SHALL cover this case: rst_n low during FILT -> all outputs 0 next cycle, no pulse; a second en rising edge 1 cycle into CLASS -> ignored, frame_cnt +1 only.

Source files
------------

// File: rtl/gesture_classify.sv
// Per-frame hand gesture classifier: derives a raw class from the detector's bounding box
// and fingertip ratio, debounces it over STABLE_N frames and drops it after a frame timeout.
module gesture_classify #(
    parameter int MIN_W    = 16,
    parameter int MIN_H    = 16,
    parameter int TH1      = 40,
    parameter int TH2      = 25,
    parameter int TH3      = 15,
    parameter int STABLE_N = 3,
    parameter int TIMEOUT  = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] x_min,
    input  logic [11:0] x_max,
    input  logic [11:0] y_min,
    input  logic [11:0] y_max,
    input  logic [19:0] fingertip_data,
    output logic [2:0]  raw_class,
    output logic [2:0]  gesture,
    output logic        gesture_valid,
    output logic        no_frame,
    output logic [15:0] frame_cnt
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLASS  = 2'd1;
    localparam logic [1:0] S_FILT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(STABLE_N + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_N);
    localparam logic [11:0]   MIN_W_C  = 12'(MIN_W);
    localparam logic [11:0]   MIN_H_C  = 12'(MIN_H);
    localparam logic [19:0]   TH1_C    = 20'(TH1);
    localparam logic [19:0]   TH2_C    = 20'(TH2);
    localparam logic [19:0]   TH3_C    = 20'(TH3);

    logic [1:0]    state_reg;
    logic          en_reg;
    logic [11:0]   x_min_reg, x_max_reg, y_min_reg, y_max_reg;
    logic [19:0]   fd_reg;
    logic [2:0]    raw_class_reg, gesture_reg, cand_reg;
    logic          gv_reg, no_frame_reg;
    logic [15:0]   frame_cnt_reg;
    logic [CW-1:0] cnt_reg;
    logic [TW-1:0] tcnt_reg;

    logic          strobe, accept, timeout_hit;
    logic [11:0]   w, h;
    logic [2:0]    class_c;

    assign strobe      = en && !en_reg;
    assign accept      = strobe && (state_reg == S_IDLE);
    assign timeout_hit = (tcnt_reg == T_LAST) && !accept;

    // Inverted or degenerate boxes count as zero size and therefore as "no hand".
    assign w = (x_max_reg > x_min_reg) ? (x_max_reg - x_min_reg) : 12'd0;
    assign h = (y_max_reg > y_min_reg) ? (y_max_reg - y_min_reg) : 12'd0;

    always_comb begin
        class_c = 3'd4;
        if (w < MIN_W_C || h < MIN_H_C) class_c = 3'd0;
        else if (fd_reg >= TH1_C)       class_c = 3'd1;
        else if (fd_reg >= TH2_C)       class_c = 3'd2;
        else if (fd_reg >= TH3_C)       class_c = 3'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            en_reg        <= 1'b0;
            x_min_reg     <= '0;
            x_max_reg     <= '0;
            y_min_reg     <= '0;
            y_max_reg     <= '0;
            fd_reg        <= '0;
            raw_class_reg <= '0;
            gesture_reg   <= '0;
            cand_reg      <= '0;
            cnt_reg       <= '0;
            gv_reg        <= 1'b0;
            no_frame_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            tcnt_reg      <= '0;
        end else begin
            en_reg <= en;
            gv_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (strobe) begin
                        x_min_reg <= x_min;
                        x_max_reg <= x_max;
                        y_min_reg <= y_min;
                        y_max_reg <= y_max;
                        fd_reg    <= fingertip_data;
                        state_reg <= S_CLASS;
                    end
                end
                S_CLASS: begin
                    raw_class_reg <= class_c;
                    state_reg     <= S_FILT;
                end
                S_FILT: begin
                    if (raw_class_reg == cand_reg) begin
                        if (cnt_reg != STABLE_C) cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        cand_reg <= raw_class_reg;
                        cnt_reg  <= CW'(1);
                    end
                    state_reg <= S_COMMIT;
                end
                default: begin
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    if (cnt_reg == STABLE_C && cand_reg != gesture_reg) begin
                        gesture_reg <= cand_reg;
                        gv_reg      <= 1'b1;
                    end
                    state_reg <= S_IDLE;
                end
            endcase

            // Timeout handling is placed last so a drop overrides any same-cycle filter update.
            if (accept) begin
                tcnt_reg     <= '0;
                no_frame_reg <= 1'b0;
            end else if (timeout_hit) begin
                no_frame_reg <= 1'b1;
                gesture_reg  <= '0;
                cand_reg     <= '0;
                cnt_reg      <= '0;
                gv_reg       <= (gesture_reg != 3'd0);
            end else begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end
        end
    end

    assign raw_class     = raw_class_reg;
    assign gesture       = gesture_reg;
    assign gesture_valid = gv_reg;
    assign no_frame      = no_frame_reg;
    assign frame_cnt     = frame_cnt_reg;
endmodule
